// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
// Supports 5..9 data bits, optional odd/even parity and 1 or 2 stop bits.
// A one-entry holding register lets a producer queue the next word while a
// frame is on the line, so consecutive frames leave no idle gap.
module uart_tx_frame #(
   parameter int CLK_FREQ_KHz  = 50000,
   parameter int BAUD_RATE_BPS = 115200,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1,
   parameter int BIT_CLOCKS    = (CLK_FREQ_KHz * 1000) / BAUD_RATE_BPS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 data_valid,
   output logic                 data_ready,
   input  logic [DATA_BITS-1:0] data,
   output logic                 tx,
   output logic                 tx_en,
   output logic                 tx_done,
   output logic                 busy
);

   localparam int BCW = $clog2(BIT_CLOCKS);
   localparam int DCW = $clog2(DATA_BITS);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(BIT_CLOCKS - 1);
   localparam logic [DCW-1:0] DATA_LAST = DCW'(DATA_BITS - 1);
   localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

   // Reject configurations the datapath cannot represent.
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (BIT_CLOCKS < 2) begin : g_bad_bit_clocks
      $error("uart_tx_frame: BIT_CLOCKS must be at least 2");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t               state;
   logic [BCW-1:0]       bit_cnt;
   logic [DCW-1:0]       data_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 parity_bit;
   logic                 hold_full;
   logic [DATA_BITS-1:0] hold_data;

   logic                 xfer;
   logic                 bit_end;
   logic                 frame_end;
   logic                 load_now;
   logic [DATA_BITS-1:0] load_src;

   // Parity over the whole word: even mode makes the total count of ones
   // even, odd mode makes it odd.
   function automatic logic calc_parity(input logic [DATA_BITS-1:0] w);
      return (PARITY == 1) ? ~^w : ^w;
   endfunction

   // Handshake, bit-boundary detection and the choice of the next word to send.
   // A held word always has priority over a new offer; data_ready is forced
   // low while reset is asserted.
   always_comb begin
      data_ready = rst & ~hold_full;
      busy       = (state != ST_IDLE) | hold_full;
      xfer       = data_valid & data_ready;
      bit_end    = (bit_cnt == BIT_LAST);
      frame_end  = (state == ST_STOP) && bit_end && (stop_cnt == STOP_LAST);
      load_now   = ((state == ST_IDLE) || frame_end) && (hold_full || xfer);
      load_src   = hold_full ? hold_data : data;
   end

   // Frame sequencer with registered line outputs; a new frame may start on
   // the same edge the previous one ends, giving back-to-back frames.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         data_cnt   <= '0;
         stop_cnt   <= 1'b0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         hold_full  <= 1'b0;
         hold_data  <= '0;
         tx         <= 1'b1;
         tx_en      <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (state != ST_IDLE) begin
            bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
         end

         case (state)
            ST_IDLE: begin
               tx    <= 1'b1;
               tx_en <= 1'b0;
            end
            ST_START: begin
               if (bit_end) begin
                  state <= ST_DATA;
                  tx    <= shift_reg[0];
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (data_cnt == DATA_LAST) begin
                     data_cnt <= '0;
                     stop_cnt <= 1'b0;
                     if (PARITY != 0) begin
                        state <= ST_PARITY;
                        tx    <= parity_bit;
                     end else begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     data_cnt  <= data_cnt + 1'b1;
                     shift_reg <= shift_reg >> 1;
                     tx        <= shift_reg[1];
                  end
               end
            end
            ST_PARITY: begin
               if (bit_end) begin
                  state    <= ST_STOP;
                  stop_cnt <= 1'b0;
                  tx       <= 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  if (stop_cnt == STOP_LAST) begin
                     tx_done  <= 1'b1;
                     stop_cnt <= 1'b0;
                     state    <= ST_IDLE;
                     tx       <= 1'b1;
                     tx_en    <= 1'b0;
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               tx    <= 1'b1;
               tx_en <= 1'b0;
            end
         endcase

         if (load_now) begin
            state      <= ST_START;
            shift_reg  <= load_src;
            parity_bit <= calc_parity(load_src);
            bit_cnt    <= '0;
            data_cnt   <= '0;
            stop_cnt   <= 1'b0;
            hold_full  <= 1'b0;
            tx         <= 1'b0;
            tx_en      <= 1'b1;
         end else if (xfer && (state != ST_IDLE)) begin
            hold_data <= data;
            hold_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: three differently configured transmitters driven with
// directed and random traffic, each compared cycle by cycle against a
// frame-level reference model.
module tb_uart_tx_frame;

   logic clk = 1'b0;
   logic rst;

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   logic       validIn[3];
   logic [8:0] dataIn[3];
   logic       readyS[3];
   logic       txS[3];
   logic       txEnS[3];
   logic       doneS[3];
   logic       busyS[3];

   int bcP[3]  = '{10, 4, 3};
   int dbP[3]  = '{8, 5, 9};
   int parP[3] = '{0, 2, 1};
   int sbP[3]  = '{1, 2, 1};

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   bit         active[3];
   int         frameStart[3];
   logic [8:0] word[3];
   bit         pendFull[3];
   logic [8:0] pendWord[3];
   bit         expDone[3];

   uart_tx_frame #(.CLK_FREQ_KHz(1000), .BAUD_RATE_BPS(100000),
                   .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
      .clk(clk), .rst(rst), .data_valid(validIn[0]), .data_ready(readyS[0]),
      .data(dataIn[0][7:0]), .tx(txS[0]), .tx_en(txEnS[0]),
      .tx_done(doneS[0]), .busy(busyS[0]));

   uart_tx_frame #(.CLK_FREQ_KHz(1000), .BAUD_RATE_BPS(250000),
                   .DATA_BITS(5), .PARITY(2), .STOP_BITS(2)) dutB (
      .clk(clk), .rst(rst), .data_valid(validIn[1]), .data_ready(readyS[1]),
      .data(dataIn[1][4:0]), .tx(txS[1]), .tx_en(txEnS[1]),
      .tx_done(doneS[1]), .busy(busyS[1]));

   uart_tx_frame #(.CLK_FREQ_KHz(1200), .BAUD_RATE_BPS(400000),
                   .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) dutC (
      .clk(clk), .rst(rst), .data_valid(validIn[2]), .data_ready(readyS[2]),
      .data(dataIn[2][8:0]), .tx(txS[2]), .tx_en(txEnS[2]),
      .tx_done(doneS[2]), .busy(busyS[2]));

   task automatic checkOutput(input string tag, input int inst, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s inst=%0d cyc=%0d got=%b expected=%b", tag, inst, cyc, actual, expected);
      end
   endtask

   function automatic int frameLen(input int i);
      return (1 + dbP[i] + ((parP[i] != 0) ? 1 : 0) + sbP[i]) * bcP[i];
   endfunction

   // Line level k cycles into a frame, from the frame layout:
   // start bit, data LSB first, optional parity, stop bits.
   function automatic logic expBit(input int i, input int k);
      int idx;
      int ones;
      idx  = k / bcP[i];
      ones = $countones(word[i]);
      if (idx == 0) return 1'b0;
      if (idx <= dbP[i]) return word[i][idx-1];
      if (parP[i] != 0 && idx == dbP[i] + 1)
         return (parP[i] == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
      return 1'b1;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         active[i]   = 1'b0;
         pendFull[i] = 1'b0;
         expDone[i]  = 1'b0;
      end
   endtask

   task automatic startFrame(input int i, input logic [8:0] w);
      active[i]     = 1'b1;
      frameStart[i] = cyc;
      word[i]       = w;
   endtask

   // One clock edge of the reference: a frame ends after frameLen cycles,
   // the held word (or a same-edge offer) follows immediately, and offers
   // made during a frame are held while the one-entry holding slot is free.
   task automatic modelStep(input int i);
      bit         xfer;
      logic [8:0] mask;
      logic [8:0] w;
      mask = 9'((1 << dbP[i]) - 1);
      w    = dataIn[i] & mask;
      xfer = validIn[i] && !pendFull[i];
      expDone[i] = 1'b0;
      if (active[i] && (cyc - frameStart[i] == frameLen(i))) begin
         expDone[i] = 1'b1;
         if (pendFull[i]) begin
            startFrame(i, pendWord[i]);
            pendFull[i] = 1'b0;
         end else if (xfer) begin
            startFrame(i, w);
         end else begin
            active[i] = 1'b0;
         end
      end else if (!active[i]) begin
         if (xfer) startFrame(i, w);
      end else if (xfer) begin
         pendFull[i] = 1'b1;
         pendWord[i] = w;
      end
   endtask

   task automatic checkAll();
      for (int i = 0; i < 3; i++) begin
         checkOutput("tx", i, txS[i], active[i] ? expBit(i, cyc - frameStart[i]) : 1'b1);
         checkOutput("tx_en", i, txEnS[i], active[i]);
         checkOutput("tx_done", i, doneS[i], expDone[i]);
         checkOutput("busy", i, busyS[i], active[i] || pendFull[i]);
         checkOutput("data_ready", i, readyS[i], rst && !pendFull[i]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         cyc++;
         for (int i = 0; i < 3; i++) modelStep(i);
      end
      @(negedge clk);
      checkAll();
   endtask

   task automatic applyStimulus(input logic v, input logic [8:0] d);
      for (int i = 0; i < 3; i++) begin
         validIn[i] = v;
         dataIn[i]  = d;
      end
   endtask

   task automatic sendWord(input logic [8:0] d, input int gap);
      applyStimulus(1'b1, d);
      tick();
      applyStimulus(1'b0, d);
      repeat (gap) tick();
   endtask

   // Asynchronous reset between edges: outputs must go idle at once.
   task automatic pulseReset();
      #1 rst = 1'b0;
      modelReset();
      #1 checkAll();
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Directed scenarios first, then random traffic with occasional resets.
   initial begin
      applyStimulus(1'b0, 9'h000);
      modelReset();
      rst = 1'b1;
      #1 rst = 1'b0;
      #1 checkAll();
      tick();
      tick();
      rst = 1'b1;
      tick();

      sendWord(9'h0A5, 130);
      sendWord(9'h007, 130);
      sendWord(9'h013, 130);

      sendWord(9'h055, 29);
      sendWord(9'h00F, 260);

      sendWord(9'h000, 10);
      applyStimulus(1'b1, 9'h011);
      repeat (5) tick();
      applyStimulus(1'b1, 9'h022);
      repeat (5) tick();
      applyStimulus(1'b1, 9'h033);
      repeat (5) tick();
      applyStimulus(1'b0, 9'h000);
      repeat (260) tick();

      sendWord(9'h03C, 35);
      pulseReset();
      tick();
      sendWord(9'h0C3, 130);

      for (int n = 0; n < 4000; n++) begin
         for (int i = 0; i < 3; i++) begin
            validIn[i] = ($urandom_range(0, 99) < 25);
            dataIn[i]  = 9'($urandom);
         end
         tick();
         if ($urandom_range(0, 799) == 0) pulseReset();
      end
      applyStimulus(1'b0, 9'h000);
      repeat (150) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
